// File: rtl/spi_command_decoder.sv
// SPI command decoder: assembles 32-bit command words from a strobed bit stream
// and applies WRITE/START/STOP/CLEAR effects two cycles after the last bit.
module spi_command_decoder #(
  parameter int REG_WIDTH = 16,
  parameter int NUM_REGS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serialIn,
  input  logic                 serialEn,
  input  logic                 frameActive,
  output logic [REG_WIDTH-1:0] cfg0,
  output logic [REG_WIDTH-1:0] cfg1,
  output logic [REG_WIDTH-1:0] cfg2,
  output logic [REG_WIDTH-1:0] cfg3,
  output logic                 startPulse,
  output logic                 running,
  output logic                 wordStrobe,
  output logic                 errorFlag
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_START = 4'h2;
  localparam logic [3:0] OP_STOP  = 4'h3;
  localparam logic [3:0] OP_CLEAR = 4'h4;

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] shift_reg, shift_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [31:0] word_reg;
  logic        pend_reg;
  logic        take_bit;
  logic        trunc;
  logic        word_done;

  logic [3:0]  opcode;
  logic        op_illegal;
  logic [NUM_REGS-1:0] wr_en;

  assign take_bit = frameActive && serialEn;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Bits are accepted in every state while the frame is open, so a strobe
  // landing in DECODE becomes the first bit of the following word.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    trunc      = 1'b0;
    word_done  = 1'b0;
    if (take_bit) begin
      shift_next = {shift_reg[30:0], serialIn};
      cnt_next   = cnt_reg + 5'd1;
    end
    case (state_reg)
      IDLE: begin
        if (frameActive) state_next = SHIFT;
      end
      SHIFT: begin
        if (!frameActive) begin
          state_next = IDLE;
          cnt_next   = '0;
          shift_next = '0;
          trunc      = (cnt_reg != 5'd0);
        end else if (take_bit && cnt_reg == 5'd31) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        word_done  = 1'b1;
        state_next = frameActive ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Completed word is held for one cycle, then its effects are applied.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_reg <= '0;
      pend_reg <= 1'b0;
    end else begin
      pend_reg <= word_done;
      if (word_done) word_reg <= shift_reg;
    end
  end

  assign opcode     = word_reg[31:28];
  assign op_illegal = (opcode > OP_CLEAR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      startPulse <= 1'b0;
      wordStrobe <= 1'b0;
      running    <= 1'b0;
      errorFlag  <= 1'b0;
    end else begin
      wordStrobe <= pend_reg;
      startPulse <= pend_reg && (opcode == OP_START);
      if (pend_reg && opcode == OP_START) running <= 1'b1;
      else if (pend_reg && opcode == OP_STOP) running <= 1'b0;
      // Setting the error wins over a CLEAR applied in the same cycle.
      if (trunc || (pend_reg && op_illegal)) errorFlag <= 1'b1;
      else if (pend_reg && opcode == OP_CLEAR) errorFlag <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
    logic [REG_WIDTH-1:0] cfg_q;
    assign wr_en[gi] = pend_reg && (opcode == OP_WRITE) && (word_reg[27:26] == 2'(gi));
    always_ff @(posedge clk) begin
      if (!reset) cfg_q <= '0;
      else if (wr_en[gi]) cfg_q <= word_reg[REG_WIDTH-1:0];
    end
  end

  assign cfg0 = g_cfg[0].cfg_q;
  assign cfg1 = g_cfg[1].cfg_q;
  assign cfg2 = g_cfg[2].cfg_q;
  assign cfg3 = g_cfg[3].cfg_q;

endmodule

// File: tb/tb_spi_command_decoder.sv
// Bench for spi_command_decoder: cycle-level word model with a delayed effect
// queue, compared every cycle, plus literal expectations per scenario.
module tb_spi_command_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        serialIn = 1'b0;
  logic        serialEn = 1'b0;
  logic        frameActive = 1'b0;
  logic [15:0] cfg0, cfg1, cfg2, cfg3;
  logic        startPulse, running, wordStrobe, errorFlag;

  spi_command_decoder #(.REG_WIDTH(16), .NUM_REGS(4)) dut (
    .clk(clk), .reset(reset), .serialIn(serialIn), .serialEn(serialEn),
    .frameActive(frameActive), .cfg0(cfg0), .cfg1(cfg1), .cfg2(cfg2),
    .cfg3(cfg3), .startPulse(startPulse), .running(running),
    .wordStrobe(wordStrobe), .errorFlag(errorFlag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: words take effect two edges after the edge that takes their last bit.
  typedef struct {
    int          due;
    logic [31:0] w;
  } ev_t;
  ev_t         q[$];
  int          cyc = 0;
  int          m_bits = 0;
  logic [31:0] m_acc = '0;
  logic [15:0] m_cfg [4];
  logic        m_run = 0, m_err = 0, m_ws = 0, m_sp = 0;

  task automatic apply_word(input logic [31:0] w);
    m_ws = 1'b1;
    case (w[31:28])
      4'h0: ;
      4'h1: m_cfg[w[27:26]] = w[15:0];
      4'h2: begin m_sp = 1'b1; m_run = 1'b1; end
      4'h3: m_run = 1'b0;
      4'h4: m_err = 1'b0;
      default: m_err = 1'b1;
    endcase
  endtask

  always @(posedge clk) begin
    ev_t e;
    cyc++;
    m_ws = 1'b0;
    m_sp = 1'b0;
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_cfg[i] = '0;
      m_run = 0; m_err = 0; m_bits = 0; m_acc = '0;
      q.delete();
    end else begin
      while (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        apply_word(e.w);
      end
      if (frameActive && serialEn) begin
        m_acc = {m_acc[30:0], serialIn};
        m_bits++;
        if (m_bits == 32) begin
          q.push_back('{cyc + 2, m_acc});
          m_bits = 0;
        end
      end else if (!frameActive && m_bits != 0) begin
        m_err  = 1'b1;
        m_bits = 0;
      end
    end
  end

  // Per-cycle compare and pulse counters.
  logic cmp_en = 1'b0;
  int   ws_cnt = 0, sp_cnt = 0;
  logic run_seen = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if ({cfg0, cfg1, cfg2, cfg3} !== {m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]} ||
          {startPulse, running, wordStrobe, errorFlag} !== {m_sp, m_run, m_ws, m_err}) begin
        n_bad++;
        $display("FAIL cycle%0d: got cfg=%h/%h/%h/%h sp=%b run=%b ws=%b err=%b want cfg=%h/%h/%h/%h sp=%b run=%b ws=%b err=%b",
                 cyc, cfg0, cfg1, cfg2, cfg3, startPulse, running, wordStrobe, errorFlag,
                 m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3], m_sp, m_run, m_ws, m_err);
      end
      if (wordStrobe === 1'b1) ws_cnt++;
      if (startPulse === 1'b1) sp_cnt++;
      if (running === 1'b1) run_seen = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      serialIn = w[31-k];
      serialEn = 1'b1;
      tick();
      serialEn = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_bits(w, 32, gap);
    $display("word %h sent (gap %0d)", w, gap);
  endtask

  task automatic frame_on;
    frameActive = 1'b1;
    tick(); tick();
  endtask

  task automatic frame_off;
    frameActive = 1'b0;
    repeat (4) tick();
  endtask

  task automatic clr_counts;
    ws_cnt = 0; sp_cnt = 0; run_seen = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int gaps[2] = '{4, 1};
    tick();
    cmp_en = 1'b1;
    check("reset_cfg", {cfg0, cfg1}, 32'h0);
    check("reset_flags", {28'h0, startPulse, running, wordStrobe, errorFlag}, 32'h0);
    reset = 1'b1;
    tick();

    foreach (gaps[gx]) begin
      int gap = gaps[gx];
      do_reset();

      // WRITE addr1, with explicit latency check on the last bit.
      clr_counts();
      frame_on();
      send_bits(32'h1400_BEEF, 31, gap);
      serialIn = 1'b1; serialEn = 1'b1;
      tick();
      serialEn = 1'b0;
      check("lat_e0", {31'h0, wordStrobe}, 32'h0);
      tick();
      check("lat_e1", {cfg1, 15'h0, wordStrobe}, 32'h0);
      tick();
      check("lat_e2", {cfg1, 15'h0, wordStrobe}, {16'hBEEF, 16'h1});
      frame_off();
      check("write_cfg", {cfg0, cfg1}, {16'h0000, 16'hBEEF});
      check("write_cfg23", {cfg2, cfg3}, 32'h0);
      check("write_ws", ws_cnt, 1);
      check("write_err", {31'h0, errorFlag}, 32'h0);

      // START then STOP in one frame.
      clr_counts();
      frame_on();
      send_word(32'h2000_0000, gap);
      send_word(32'h3000_0000, gap);
      frame_off();
      check("ss_sp", sp_cnt, 1);
      check("ss_ws", ws_cnt, 2);
      check("ss_runseen", {31'h0, run_seen}, 32'h1);
      check("ss_run", {31'h0, running}, 32'h0);

      // Truncation after 17 bits, then CLEAR.
      frame_on();
      send_bits(32'h1800_1111, 17, gap);
      frame_off();
      check("trunc_err", {31'h0, errorFlag}, 32'h1);
      check("trunc_cfg", {cfg1, cfg2}, {16'hBEEF, 16'h0000});
      frame_on();
      send_word(32'h4000_0000, gap);
      frame_off();
      check("clear_err", {31'h0, errorFlag}, 32'h0);

      // Illegal opcode.
      clr_counts();
      frame_on();
      send_word(32'hF000_1234, gap);
      frame_off();
      check("ill_err", {31'h0, errorFlag}, 32'h1);
      check("ill_ws", ws_cnt, 1);
      check("ill_cfg", {cfg0, cfg1}, {16'h0000, 16'hBEEF});
      check("ill_run", {31'h0, running}, 32'h0);

      // STOP while idle, START twice.
      clr_counts();
      frame_on();
      send_word(32'h3000_0000, gap);
      send_word(32'h2000_0000, gap);
      send_word(32'h2000_0000, gap);
      frame_off();
      check("dbl_sp", sp_cnt, 2);
      check("dbl_ws", ws_cnt, 3);
      check("dbl_run", {31'h0, running}, 32'h1);

      // Reset after 10 bits of a WRITE, then a full WRITE addr3.
      frame_on();
      send_bits(32'h1C00_A5A5, 10, gap);
      reset = 1'b0;
      tick();
      frameActive = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("rst_mid_err", {31'h0, errorFlag}, 32'h0);
      frame_on();
      send_word(32'h1C00_A5A5, gap);
      frame_off();
      check("rst_cfg3", {cfg0, cfg3}, {16'h0000, 16'hA5A5});
      check("rst_err", {31'h0, errorFlag}, 32'h0);
    end

    // CLEAR landing on the same edge as a truncation: error stays set.
    frame_on();
    send_word(32'hE000_0000, 1);
    send_bits(32'h4000_0000, 32, 1);
    serialIn = 1'b0; serialEn = 1'b1;
    tick();
    serialEn = 1'b0;
    frameActive = 1'b0;
    repeat (4) tick();
    check("clr_trunc_err", {31'h0, errorFlag}, 32'h1);

    // NOP and WRITE to addr0/addr2 at max rate.
    frame_on();
    send_word(32'h0000_FFFF, 1);
    send_word(32'h1000_1234, 1);
    send_word(32'h1800_5678, 1);
    frame_off();
    check("wr02", {cfg0, cfg2}, {16'h1234, 16'h5678});

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_command_decoder.md
SPI_COMMAND_DECODER -- requirements
Module: spi_command_decoder

Interface
REQ-001 Parameter: REG_WIDTH, 16, width of each configuration register (fixed at 16 in this revision).
REQ-002 Parameter: NUM_REGS, 4, number of configuration registers; address field is 2 bits.
REQ-003 Port: clk  input  1  system clock (32 MHz); all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 Port: serialIn  input  1  deserialized SPI data bit, valid when serialEn high.
REQ-006 Port: serialEn  input  1  single-cycle strobe per received bit, MSB first.
REQ-007 Port: frameActive  input  1  synchronized chip-select, high while a transaction is in progress.
REQ-008 Port: cfg0..cfg3  output  16 each  configuration register contents.
REQ-009 Port: startPulse  output  1  one-cycle pulse on accepted START command.
REQ-010 Port: running  output  1  level, set by START, cleared by STOP.
REQ-011 Port: wordStrobe  output  1  one-cycle pulse when any complete 32-bit word is decoded.
REQ-012 Port: errorFlag  output  1  sticky: truncated frame or illegal opcode; cleared by CLEAR command or reset.

Function
REQ-013 Word format SHALL be: [31:28] opcode, [27:26] address, [25:16] ignored, [15:0] data.
REQ-014 Opcodes SHALL be: 0x1 WRITE (cfg[address] <= data), 0x2 START, 0x3 STOP, 0x4 CLEAR (errorFlag <= 0), 0x0 NOP; all others illegal.
REQ-015 FSM states SHALL be IDLE, SHIFT, DECODE; IDLE->SHIFT when frameActive high; SHIFT->DECODE on 32nd serialEn; DECODE->SHIFT if frameActive high else IDLE, after exactly one cycle.
REQ-016 In SHIFT, each serialEn SHALL shift serialIn into bit 0 of a 32-bit shift register and increment a 5-bit bit counter; counter wraps 31->0 on the 32nd bit.
REQ-017 serialEn while frameActive low SHALL be ignored.
REQ-018 Effects of a word (register update, startPulse, running change, wordStrobe) SHALL be visible on outputs exactly 2 clk cycles after the rising edge sampling the 32nd serialEn.
REQ-019 Multiple words in one frame SHALL be decoded back-to-back; a serialEn arriving during DECODE SHALL be captured as bit 31 of the next word (no bit loss).
REQ-020 frameActive falling with bit counter nonzero SHALL discard the partial word, set errorFlag, zero the counter, return to IDLE; no register change.
REQ-021 frameActive falling with counter zero SHALL return to IDLE without error.
REQ-022 Illegal opcode SHALL set errorFlag, assert wordStrobe, change no other state.
REQ-023 START while running already high SHALL still pulse startPulse; STOP while not running SHALL be a no-op (wordStrobe only).
REQ-024 WRITE SHALL update only the addressed register; others hold.
REQ-025 CLEAR coincident with a truncation in the same cycle SHALL leave errorFlag set (set wins).

Reset
REQ-026 With reset low at a rising clk: state IDLE, shift register and counter 0, cfg0..cfg3 = 0x0000, running = 0, startPulse = 0, wordStrobe = 0, errorFlag = 0.
REQ-027 Reset mid-frame SHALL discard the partial word without setting errorFlag; decoding resumes on the next frameActive rising after reset released.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-029 Frame 0x1400_BEEF (WRITE addr1) -> cfg1 = 0xBEEF, cfg0/2/3 = 0, one wordStrobe, errorFlag = 0.
REQ-030 One frame with 0x2000_0000 then 0x3000_0000 -> startPulse one cycle, running 1 then 0, two wordStrobes.
REQ-031 Frame deasserted after 17 bits -> errorFlag = 1, all cfg unchanged; then frame 0x4000_0000 -> errorFlag = 0.
REQ-032 Frame 0xF000_1234 -> errorFlag = 1, no cfg change, running unchanged, wordStrobe pulses once.
REQ-033 Reset low after 10 bits of a WRITE, then frame 0x1C00_A5A5 -> cfg3 = 0xA5A5, errorFlag = 0.
REQ-034 All scenarios at 8 MHz bit rate (serialEn every 4 clk) and at maximal rate (serialEn every clk) -> identical results, outputs update 2 cycles after the 32nd strobe.
